// File: rtl/flappy_button_conditioner.sv
// Turns one raw push-button into a debounced level, a one-clock press pulse and a
// sticky request held until the game tick consumes it. Optional macro: FLAP_AUTOREPEAT_EN.
module flappy_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 25,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_btn,
  input  logic i_tick,
  output logic o_btn_level,
  output logic o_press_pulse,
  output logic o_pending,
  output logic o_overrun
);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reject configurations where the counters could not reach their terminal count.
  if (DEBOUNCE_CYCLES < 2 ||
      (64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES) ||
      (64'd1 << CNT_W) <= 64'(REPEAT_CYCLES)) begin : g_bad_params
    $error("flappy_button_conditioner: invalid DEBOUNCE_CYCLES/REPEAT_CYCLES/CNT_W");
  end

  logic             r_s1;
  logic             r_s2;
  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_debounce_pulse;
  logic             w_press_next;
  logic             w_level_next;
  logic             r_level;
  logic             r_pulse;
  logic             r_pending;
  logic             r_overrun;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_btn;
      r_s2 <= r_s1;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_debounce_pulse = 1'b0;
    unique case (r_state)
      RELEASED: begin
        if (r_s2) begin
          w_state_next = PRESS_WAIT;
          w_cnt_next   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!r_s2) begin
          w_state_next = RELEASED;
        end else if (r_cnt == DEB_LAST) begin
          w_state_next     = PRESSED;
          w_debounce_pulse = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!r_s2) begin
          w_state_next = RELEASE_WAIT;
          w_cnt_next   = '0;
        end
      end
      RELEASE_WAIT: begin
        // A return to pressed here is contact bounce, so no fresh pulse.
        if (r_s2) begin
          w_state_next = PRESSED;
        end else if (r_cnt == DEB_LAST) begin
          w_state_next = RELEASED;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_next = RELEASED;
      end
    endcase
    w_level_next = (w_state_next == PRESSED) || (w_state_next == RELEASE_WAIT);
  end

`ifdef FLAP_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic [CNT_W-1:0] r_rep_cnt;
  logic [CNT_W-1:0] w_rep_cnt_next;
  logic             w_rep_pulse;

  // Runs only while settled in PRESSED; RELEASE_WAIT leaves it frozen.
  always_comb begin
    w_rep_cnt_next = r_rep_cnt;
    w_rep_pulse    = 1'b0;
    if (r_state == PRESS_WAIT && w_state_next == PRESSED) begin
      w_rep_cnt_next = '0;
    end else if (r_state == PRESSED && w_state_next == PRESSED) begin
      if (r_rep_cnt == REP_LAST) begin
        w_rep_pulse    = 1'b1;
        w_rep_cnt_next = '0;
      end else begin
        w_rep_cnt_next = r_rep_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rep_cnt <= '0;
    end else begin
      r_rep_cnt <= w_rep_cnt_next;
    end
  end

  assign w_press_next = w_debounce_pulse | w_rep_pulse;
`else
  assign w_press_next = w_debounce_pulse;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= RELEASED;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_level <= w_level_next;
      r_pulse <= w_press_next;
    end
  end

  // A press landing on the consuming tick wins, so pending stays set.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_pending <= r_pulse | (r_pending & ~i_tick);
      r_overrun <= r_overrun | (r_pulse & r_pending & ~i_tick);
    end
  end

  assign o_btn_level   = r_level;
  assign o_press_pulse = r_pulse;
  assign o_pending     = r_pending;
  assign o_overrun     = r_overrun;

endmodule
